// File: rtl/riscv_pkg.sv
// Shared opcode, state and constant definitions for the multi-cycle sequencer.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    function automatic logic is_legal_opcode(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Immediate extraction: picks the I/S/B/J/U format from the opcode and
// sign-extends it to XLEN.
module riscv_imm_gen
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     i_ir,
    output logic [XLEN-1:0] o_imm
);

    logic signed [31:0] w_imm32;

    always_comb begin
        w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
        case (i_ir[6:0])
            OPC_STORE:  w_imm32 = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
            OPC_BRANCH: w_imm32 = {{19{i_ir[31]}}, i_ir[31], i_ir[7],
                                   i_ir[30:25], i_ir[11:8], 1'b0};
            OPC_JAL:    w_imm32 = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12],
                                   i_ir[20], i_ir[30:21], 1'b0};
            OPC_LUI,
            OPC_AUIPC:  w_imm32 = {i_ir[31:12], 12'b0};
            default:    w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
        endcase
    end

    // Signed source makes the size cast a sign extension.
    assign o_imm = XLEN'(w_imm32);

endmodule

// File: rtl/riscv_mc_sequencer.sv
// Multi-cycle RISC-V control sequencer: owns PC, IR, ALU latch and writeback,
// sharing one req/ready memory port between fetch and data access.
module riscv_mc_sequencer
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_cmp,
    output logic [31:0]     ir,
    output logic [XLEN-1:0] pc,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [2:0]      state,
    output logic            retire,
    output logic [XLEN-1:0] instret,
    output logic            halted
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_alu;
    logic            r_cmp;
    logic [XLEN-1:0] r_tgt;
    logic [XLEN-1:0] r_ld;
    logic [XLEN-1:0] r_instret;
    logic            r_halted;

    logic [6:0]      w_opc;
    logic            w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr;
    logic            w_rd_write;
    logic            w_taken;
    logic            w_misalign;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_tgt;
    logic [XLEN-1:0] w_npc;

    riscv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_ir  (r_ir),
        .o_imm (w_imm)
    );

    assign w_opc       = r_ir[6:0];
    assign w_is_load   = (w_opc == OPC_LOAD);
    assign w_is_store  = (w_opc == OPC_STORE);
    assign w_is_branch = (w_opc == OPC_BRANCH);
    assign w_is_jal    = (w_opc == OPC_JAL);
    assign w_is_jalr   = (w_opc == OPC_JALR);
    assign w_rd_write  = w_is_load || w_is_jal || w_is_jalr ||
                         (w_opc == OPC_OP) || (w_opc == OPC_OPIMM) ||
                         (w_opc == OPC_LUI) || (w_opc == OPC_AUIPC);

    assign w_pc_inc = r_pc + XLEN'(4);
    assign w_tgt    = w_is_jalr ? ((rs1_data + w_imm) & ~XLEN'(1)) : (r_pc + w_imm);

    // A not-taken branch never leaves pc+4, so only a real redirect can fault.
    assign w_misalign = (w_is_jal || w_is_jalr || (w_is_branch && alu_cmp)) &&
                        (w_tgt[1:0] != 2'b00);

    assign w_taken = w_is_jal || w_is_jalr || (w_is_branch && r_cmp);
    assign w_npc   = w_taken ? r_tgt : w_pc_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= NOP;
            r_alu     <= '0;
            r_cmp     <= 1'b0;
            r_tgt     <= '0;
            r_ld      <= '0;
            r_instret <= '0;
            r_halted  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_halted <= r_halted || (w_state_nxt == S_HALT);
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir <= mem_rdata;
                    end
                end
                S_EXEC: begin
                    r_alu <= alu_out;
                    r_cmp <= alu_cmp;
                    r_tgt <= w_tgt;
                end
                S_MEM: begin
                    if (mem_ready && w_is_load) begin
                        r_ld <= mem_rdata;
                    end
                end
                S_WB: begin
                    r_pc      <= w_npc;
                    r_instret <= r_instret + XLEN'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = r_pc;
        rf_we       = 1'b0;
        rf_wdata    = r_alu;
        retire      = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_state_nxt = is_legal_opcode(w_opc) ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                if (w_misalign) begin
                    w_state_nxt = S_HALT;
                end else if (w_is_load || w_is_store) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = w_is_store;
                mem_addr = r_alu;
                if (mem_ready) begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB: begin
                rf_we       = w_rd_write && (r_ir[11:7] != 5'd0);
                retire      = 1'b1;
                w_state_nxt = S_FETCH;
                if (w_is_load) begin
                    rf_wdata = r_ld;
                end else if (w_is_jal || w_is_jalr) begin
                    rf_wdata = w_pc_inc;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_HALT;
            end
        endcase
        // Strobes are forced low whenever reset is asserted, whatever the state.
        if (!rst_n) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            rf_we   = 1'b0;
            retire  = 1'b0;
        end
    end

    assign mem_wdata = rs2_data;
    assign ir        = r_ir;
    assign pc        = r_pc;
    assign rf_waddr  = r_ir[11:7];
    assign state     = r_state;
    assign instret   = r_instret;
    assign halted    = r_halted;

endmodule

// File: doc/riscv_mc_sequencer.md
# riscv_mc_sequencer

Multi-cycle control sequencer for the RISC-V core. It replaces the single-cycle program counter and instruction-fetch path with a state machine that owns PC, the instruction register, the ALU result latch and the writeback mux. Instruction fetch and data access share one memory port with a req/ready handshake. The external ALU, register file and operand decoder stay as they are; this block sequences them, resolves branches and jumps, and halts on illegal or misaligned instructions.

## Interface
- XLEN, 32, datapath and address width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- mem_req  out  1  memory transfer request
- mem_we  out  1  1 = store, 0 = read
- mem_addr  out  XLEN  byte address (PC in FETCH, latched ALU result in MEM)
- mem_wdata  out  XLEN  store data (rs2_data)
- mem_ready  in  1  transfer completes on a cycle with mem_req&&mem_ready
- mem_rdata  in  XLEN  read data, valid when mem_ready
- rs1_data, rs2_data  in  XLEN  register-file read ports
- alu_out  in  XLEN  ALU result, valid in EXEC
- alu_cmp  in  1  ALU compare flag, valid in EXEC
- ir  out  32  latched instruction (feeds decoder and register-file addresses)
- pc  out  XLEN  address of the current instruction
- rf_we  out  1  register write strobe
- rf_waddr  out  5  ir[11:7]
- rf_wdata  out  XLEN  writeback data
- state  out  3  current FSM state (debug)
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  XLEN  retired-instruction count, wraps modulo 2^XLEN
- halted  out  1  sticky halt flag

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. Hold until ready, then latch ir=mem_rdata and go to DECODE.
- DECODE: one cycle for register-file read settling. Opcode classes: LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111. Any other opcode goes to HALT.
- EXEC: latch alu_q=alu_out and cmp_q=alu_cmp. Compute the next PC:
  - BRANCH: pc+imm_B if cmp_q, else pc+4.
  - JAL: pc+imm_J.
  - JALR: (rs1_data+imm_I)&~1.
  - Others: pc+4.
  - If a target has [1:0]≠0, go to HALT.
  - LOAD/STORE go to MEM. All other classes go to WB.
- MEM: mem_req=1, mem_addr=alu_q, mem_we=1 for STORE. Hold until ready; a LOAD latches mem_rdata. Then go to WB.
- WB:
  - rf_we=1 for LOAD, OP, OP-IMM, LUI, AUIPC, JAL, JALR, and only when rf_waddr≠0.
  - rf_wdata = load data for LOAD, pc+4 for JAL/JALR, else alu_q.
  - pc ← next PC; retire=1; instret+1; next state FETCH.
- HALT: all strobes 0, halted=1, pc and ir frozen. Only rst_n exits.
- Addresses are XLEN-bit; additions wrap modulo 2^XLEN.

## Timing
- Reset (rst_n low at a clk edge):
  - state=FETCH, pc=RESET_PC, ir=32'h00000013 (NOP), alu_q=0, instret=0, halted=0.
  - mem_req, rf_we and retire are gated to 0 while rst_n is low. No store can occur during reset.
- Reset mid-transfer abandons the transfer. Fetch restarts at RESET_PC on the cycle after release.
- Zero-wait latency (ready in the same cycle as req): ALU/jump/branch instructions take 4 cycles; LOAD/STORE take 5. Each cycle with mem_req=1 and mem_ready=0 adds one cycle.
- Handshake:
  - mem_addr, mem_we and mem_wdata are stable from the first req cycle until completion.
  - mem_ready is ignored while mem_req=0.
  - mem_req drops the cycle after completion.
- rf_we and retire are high for exactly one cycle (WB).

## Structure
- Package riscv_pkg holds:
  - opcode localparams
  - state enum (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5)
  - NOP constant
- Sub-module riscv_imm_gen: combinational I/S/B/J/U immediate extraction with sign extension to XLEN. The ALU operand path reuses it.

## Test plan
- Hold rst_n low 3 cycles → pc=0, mem_req=0, halted=0, instret=0. First cycle after release: mem_req=1, mem_addr=0.
- Fetch 0x00500093 (addi x1,x0,5) with alu_out=5, zero wait → rf_we, rf_waddr=1, rf_wdata=5 in cycle 4. pc becomes 4; retire pulses; instret=1.
- lw with mem_ready delayed 3 cycles in MEM → mem_addr held at alu_q, rf_wdata=mem_rdata. Total 8 cycles; rf_we high one cycle.
- beq at pc=0x10, imm_B=−8: alu_cmp=1 → pc=0x08; alu_cmp=0 → pc=0x14. rf_we=0 in both cases.
- jalr x1,0(x2) at pc=0x20 with rs1_data=0x101 → pc=0x100, rf_wdata=0x24. With rs1_data=0x102 → halted=1 and pc stays 0x20.
- Fetch 0x00000000 → HALT after DECODE. mem_req and rf_we stay 0 for 20 cycles; reset clears halted.
